// File: rtl/audio_processor.sv
// Frame-based audio effects engine: pitch resample, overdrive and tremolo over a
// 2048-sample frame, one output sample per cycle through a 3-stage pipeline.
module audio_processor #(
  parameter int SAMPLE_W    = 16,
  parameter int FRAME_WORDS = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     data_wr_en,
  input  logic [5:0]               input_index,
  input  logic [32*SAMPLE_W-1:0]   data_in,
  input  logic                     pitch_shift_wr_en,
  input  logic [4:0]               pitch_shift_semitones,
  input  logic                     freq_coeff_wr_en,
  input  logic [10:0]              freq_coeff_index,
  input  logic [7:0]               freq_coeff_in,
  input  logic                     tremolo_enable_wr_en,
  input  logic                     tremolo_enable_in,
  input  logic                     overdrive_enable_wr_en,
  input  logic                     overdrive_enable_in,
  input  logic                     overdrive_magnitude_wr_en,
  input  logic [3:0]               overdrive_magnitude,
  input  logic [5:0]               output_index,
  output logic [32*SAMPLE_W-1:0]   data_out,
  output logic                     done,
  output logic [1:0]               state_dbg,
  output logic [7:0]               coeff_rd
);

  localparam int LANES  = 32;
  localparam int N_SAMP = FRAME_WORDS * LANES;
  localparam int IDX_W  = 11;
  localparam int PW     = SAMPLE_W + 6;
  localparam int TW     = SAMPLE_W + 12;
  localparam logic [IDX_W-1:0]    LAST   = IDX_W'(N_SAMP - 1);
  localparam logic signed [PW-1:0] OD_MAX = PW'(16383);
  localparam logic signed [PW-1:0] OD_MIN = PW'(-16384);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  state_t state;

  logic signed [SAMPLE_W-1:0] in_mem  [N_SAMP];
  logic signed [SAMPLE_W-1:0] out_mem [N_SAMP];
  logic [7:0]                 coeff   [N_SAMP];

  // Live configuration and the copies frozen for the frame in flight
  logic [4:0] cfg_pitch, sh_pitch;
  logic       cfg_od, sh_od, cfg_tr, sh_tr;
  logic [3:0] cfg_mag, sh_mag;

  logic [IDX_W-1:0] cnt;
  logic             issuing;
  logic             v1, v2, v3;
  logic [IDX_W-1:0] n1, n2, n3, idx1;
  logic signed [SAMPLE_W-1:0] p2, o3;

  logic [13:0]               ratio;
  logic signed [4:0]         sp_cl;
  logic [4:0]                lut_sel;
  logic [24:0]               mul;
  logic [IDX_W-1:0]          idx_next;
  logic [5:0]                od_gain;
  logic signed [PW-1:0]      od_prod;
  logic signed [SAMPLE_W-1:0] o_next;
  logic [9:0]                tri_w;
  logic [11:0]               tr_gain;
  logic signed [TW-1:0]      tr_prod;
  logic signed [SAMPLE_W-1:0] t_val;

  // Pitch ratio: round(4096 * 2^(s/12)) for s clamped to -12..+12
  always_comb begin
    sp_cl = $signed(sh_pitch);
    if (sp_cl < -5'sd12) sp_cl = -5'sd12;
    else if (sp_cl > 5'sd12) sp_cl = 5'sd12;
    lut_sel = 5'($unsigned(sp_cl) + 5'd12);
    case (lut_sel)
      5'd0:  ratio = 14'd2048;  5'd1:  ratio = 14'd2170;  5'd2:  ratio = 14'd2299;
      5'd3:  ratio = 14'd2435;  5'd4:  ratio = 14'd2580;  5'd5:  ratio = 14'd2734;
      5'd6:  ratio = 14'd2896;  5'd7:  ratio = 14'd3069;  5'd8:  ratio = 14'd3251;
      5'd9:  ratio = 14'd3444;  5'd10: ratio = 14'd3649;  5'd11: ratio = 14'd3866;
      5'd12: ratio = 14'd4096;  5'd13: ratio = 14'd4340;  5'd14: ratio = 14'd4598;
      5'd15: ratio = 14'd4871;  5'd16: ratio = 14'd5161;  5'd17: ratio = 14'd5468;
      5'd18: ratio = 14'd5793;  5'd19: ratio = 14'd6137;  5'd20: ratio = 14'd6502;
      5'd21: ratio = 14'd6889;  5'd22: ratio = 14'd7298;  5'd23: ratio = 14'd7732;
      default: ratio = 14'd8192;
    endcase
    mul      = {3'b000, cnt} * {11'b0, ratio};
    idx_next = IDX_W'(mul >> 12);
  end

  // Overdrive: full-width product, then saturate to the 15-bit headroom window
  always_comb begin
    od_gain = {2'b00, sh_mag} + 6'd1;
    od_prod = PW'(p2) * PW'($signed(od_gain));
    if (!sh_od)                o_next = p2;
    else if (od_prod > OD_MAX) o_next = SAMPLE_W'(OD_MAX);
    else if (od_prod < OD_MIN) o_next = SAMPLE_W'(OD_MIN);
    else                       o_next = SAMPLE_W'(od_prod);
  end

  // Tremolo: triangle over the frame, gain ranges 0.5 .. ~1.0
  always_comb begin
    tri_w   = n3[10] ? ~n3[9:0] : n3[9:0];
    tr_gain = 12'd1024 + {2'b00, tri_w};
    tr_prod = TW'(o3) * TW'($signed(tr_gain));
    t_val   = sh_tr ? SAMPLE_W'(tr_prod >>> 11) : o3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      cfg_pitch <= '0;
      cfg_od    <= 1'b0;
      cfg_tr    <= 1'b0;
      cfg_mag   <= '0;
      sh_pitch  <= '0;
      sh_od     <= 1'b0;
      sh_tr     <= 1'b0;
      sh_mag    <= '0;
      cnt       <= '0;
      issuing   <= 1'b0;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      n1 <= '0; n2 <= '0; n3 <= '0; idx1 <= '0;
      p2 <= '0; o3 <= '0;
      for (int i = 0; i < N_SAMP; i++) coeff[i] <= '0;
    end else begin
      if (pitch_shift_wr_en)         cfg_pitch <= pitch_shift_semitones;
      if (tremolo_enable_wr_en)      cfg_tr    <= tremolo_enable_in;
      if (overdrive_enable_wr_en)    cfg_od    <= overdrive_enable_in;
      if (overdrive_magnitude_wr_en) cfg_mag   <= overdrive_magnitude;
      if (freq_coeff_wr_en)          coeff[freq_coeff_index] <= freq_coeff_in;

      v1 <= issuing;  n1 <= cnt; idx1 <= idx_next;
      v2 <= v1;       n2 <= n1;  p2   <= in_mem[idx1];
      v3 <= v2;       n3 <= n2;  o3   <= o_next;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_RUN;
            done     <= 1'b0;
            sh_pitch <= cfg_pitch;
            sh_od    <= cfg_od;
            sh_tr    <= cfg_tr;
            sh_mag   <= cfg_mag;
            cnt      <= '0;
            issuing  <= 1'b1;
          end
        end
        S_RUN: begin
          if (issuing) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) issuing <= 1'b0;
          end
          if (v3 && n3 == LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sample buffers carry no reset; they are defined only once written
  always_ff @(posedge clk) begin
    if (data_wr_en && state != S_RUN)
      for (int k = 0; k < LANES; k++)
        in_mem[{input_index, k[4:0]}] <= data_in[k*SAMPLE_W +: SAMPLE_W];
    if (v3) out_mem[n3] <= t_val;
  end

  always_comb begin
    data_out = '0;
    for (int k = 0; k < LANES; k++)
      data_out[k*SAMPLE_W +: SAMPLE_W] = out_mem[{output_index, k[4:0]}];
  end

  assign state_dbg = state;
  assign coeff_rd  = coeff[freq_coeff_index];

endmodule

// File: tb/tb_audio_processor.sv
// Self-checking bench for audio_processor: directed frames plus randomized
// frames compared against an arithmetic reference model of the effect chain.
module tb_audio_processor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         data_wr_en;
  logic [5:0]   input_index;
  logic [511:0] data_in;
  logic         pitch_shift_wr_en;
  logic [4:0]   pitch_shift_semitones;
  logic         freq_coeff_wr_en;
  logic [10:0]  freq_coeff_index;
  logic [7:0]   freq_coeff_in;
  logic         tremolo_enable_wr_en, tremolo_enable_in;
  logic         overdrive_enable_wr_en, overdrive_enable_in;
  logic         overdrive_magnitude_wr_en;
  logic [3:0]   overdrive_magnitude;
  logic [5:0]   output_index;
  logic [511:0] data_out;
  logic         done;
  logic [1:0]   state_dbg;
  logic [7:0]   coeff_rd;

  audio_processor dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .data_wr_en(data_wr_en), .input_index(input_index), .data_in(data_in),
    .pitch_shift_wr_en(pitch_shift_wr_en), .pitch_shift_semitones(pitch_shift_semitones),
    .freq_coeff_wr_en(freq_coeff_wr_en), .freq_coeff_index(freq_coeff_index),
    .freq_coeff_in(freq_coeff_in),
    .tremolo_enable_wr_en(tremolo_enable_wr_en), .tremolo_enable_in(tremolo_enable_in),
    .overdrive_enable_wr_en(overdrive_enable_wr_en), .overdrive_enable_in(overdrive_enable_in),
    .overdrive_magnitude_wr_en(overdrive_magnitude_wr_en),
    .overdrive_magnitude(overdrive_magnitude),
    .output_index(output_index), .data_out(data_out), .done(done),
    .state_dbg(state_dbg), .coeff_rd(coeff_rd)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: input frame plus live and frozen configuration
  int in_model [2048];
  int cfg_s = 0, cfg_m = 0;
  bit cfg_od = 0, cfg_tr = 0;
  int run_s, run_m;
  bit run_od, run_tr;
  int cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_ratio(input int s);
    int sc;
    sc = (s < -12) ? -12 : (s > 12) ? 12 : s;
    return $rtoi(4096.0 * $pow(2.0, real'(sc) / 12.0) + 0.5);
  endfunction

  function automatic int ref_sample(input int n, input int s, input bit od, input int m, input bit tr);
    int idx, p, o, tv, tri_v;
    idx = ((n * ref_ratio(s)) / 4096) % 2048;
    p = in_model[idx];
    o = p;
    if (od) begin
      o = p * (m + 1);
      if (o > 16383) o = 16383;
      if (o < -16384) o = -16384;
    end
    tv = o;
    if (tr) begin
      tri_v = (n < 1024) ? n : 2047 - n;
      tv = (o * (1024 + tri_v)) >>> 11;
    end
    return tv;
  endfunction

  task automatic write_word(input int w);
    for (int k = 0; k < 32; k++) data_in[k*16 +: 16] = 16'(in_model[w*32 + k]);
    input_index = 6'(w);
    data_wr_en  = 1'b1;
    tick();
    data_wr_en  = 1'b0;
  endtask

  task automatic load_frame();
    for (int w = 0; w < 64; w++) write_word(w);
  endtask

  task automatic set_cfg(input int s, input bit od, input int m, input bit tr);
    pitch_shift_semitones = 5'(s);
    overdrive_enable_in   = od;
    overdrive_magnitude   = 4'(m);
    tremolo_enable_in     = tr;
    pitch_shift_wr_en = 1'b1; overdrive_enable_wr_en = 1'b1;
    overdrive_magnitude_wr_en = 1'b1; tremolo_enable_wr_en = 1'b1;
    tick();
    pitch_shift_wr_en = 1'b0; overdrive_enable_wr_en = 1'b0;
    overdrive_magnitude_wr_en = 1'b0; tremolo_enable_wr_en = 1'b0;
    cfg_s = s; cfg_od = od; cfg_m = m; cfg_tr = tr;
  endtask

  task automatic write_coeff(input int idx, input int val);
    freq_coeff_index = 11'(idx);
    freq_coeff_in    = 8'(val);
    freq_coeff_wr_en = 1'b1;
    tick();
    freq_coeff_wr_en = 1'b0;
  endtask

  task automatic start_frame(input string tag);
    run_s = cfg_s; run_od = cfg_od; run_m = cfg_m; run_tr = cfg_tr;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_done_clr"}, 512'(done), 512'(0));
    cyc = 0;
  endtask

  task automatic wait_done(input string tag);
    while (!done && cyc < 2200) begin
      tick();
      cyc++;
    end
    chk({tag, "_done_in_time"}, 512'(done === 1'b1 && cyc <= 2056), 512'(1));
  endtask

  task automatic check_frame(input string tag);
    logic [511:0] exp_w;
    for (int w = 0; w < 64; w++) begin
      for (int k = 0; k < 32; k++)
        exp_w[k*16 +: 16] = 16'(ref_sample(w*32 + k, run_s, run_od, run_m, run_tr));
      output_index = 6'(w);
      #1;
      chk($sformatf("%s_w%0d", tag, w), data_out, exp_w);
    end
  endtask

  task automatic chk_sample(input string tag, input int n, input int exp_v);
    logic [15:0] e16;
    e16 = 16'(exp_v);
    output_index = 6'(n / 32);
    #1;
    chk(tag, 512'(data_out[(n % 32)*16 +: 16]), 512'(e16));
  endtask

  task automatic run_and_check(input string tag);
    start_frame(tag);
    wait_done(tag);
    check_frame(tag);
  endtask

  initial begin
    int v;
    rst_n = 1'b0; start = 1'b0; data_wr_en = 1'b0; input_index = '0; data_in = '0;
    pitch_shift_wr_en = 1'b0; pitch_shift_semitones = '0;
    freq_coeff_wr_en = 1'b0; freq_coeff_index = '0; freq_coeff_in = '0;
    tremolo_enable_wr_en = 1'b0; tremolo_enable_in = 1'b0;
    overdrive_enable_wr_en = 1'b0; overdrive_enable_in = 1'b0;
    overdrive_magnitude_wr_en = 1'b0; overdrive_magnitude = '0;
    output_index = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_state_idle", 512'(state_dbg), 512'(0));
    freq_coeff_index = 11'd100;
    #1;
    chk("rst_coeff", 512'(coeff_rd), 512'(0));
    rst_n = 1'b1;
    tick();

    // Coefficient storage, including the top address
    write_coeff(5, 8'hA5);
    write_coeff(2047, 8'h3C);
    freq_coeff_index = 11'd5;    #1; chk("coeff_5", 512'(coeff_rd), 512'(8'hA5));
    freq_coeff_index = 11'd2047; #1; chk("coeff_2047", 512'(coeff_rd), 512'(8'h3C));

    // Ramp frame, all effects off: identity
    for (int i = 0; i < 2048; i++) in_model[i] = i;
    load_frame();
    run_and_check("ramp_id");
    chk("state_done", 512'(state_dbg), 512'(2));
    chk("done_held", 512'(done), 512'(1));

    // Octave down / up on the ramp
    set_cfg(-12, 0, 0, 0);
    run_and_check("oct_dn");
    chk_sample("oct_dn_n5", 5, 2);
    chk_sample("oct_dn_n2047", 2047, 1023);
    set_cfg(12, 0, 0, 0);
    run_and_check("oct_up");
    chk_sample("oct_up_n1500", 1500, 952);
    set_cfg(-2, 0, 0, 0);
    run_and_check("pitch_m2");

    // Overdrive saturation corners
    for (int i = 0; i < 2048; i++) in_model[i] = int'($signed(16'($urandom_range(0, 65535))));
    in_model[0] = 1000; in_model[1] = 2000; in_model[2] = -3000;
    load_frame();
    set_cfg(0, 1, 10, 0);
    run_and_check("od_m10");
    chk_sample("od_1000", 0, 11000);
    chk_sample("od_2000", 1, 16383);
    chk_sample("od_m3000", 2, -16384);

    // Tremolo envelope on a constant frame
    for (int i = 0; i < 2048; i++) in_model[i] = 2048;
    load_frame();
    set_cfg(0, 0, 0, 1);
    run_and_check("trem");
    chk_sample("trem_n0", 0, 1024);
    chk_sample("trem_n1023", 1023, 2047);
    chk_sample("trem_n2047", 2047, 1024);

    // Randomized frames with random configuration, pitch beyond the clamp allowed
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 2048; i++) in_model[i] = int'($signed(16'($urandom_range(0, 65535))));
      load_frame();
      v = int'($urandom_range(0, 31));
      set_cfg((v > 15) ? v - 32 : v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
      run_and_check($sformatf("rand%0d", it));
    end

    // Config change, buffer write and second start during RUN must not disturb the frame
    set_cfg(3, 0, 0, 0);
    start_frame("midcfg");
    repeat (100) begin tick(); cyc++; end
    overdrive_enable_in = 1'b1; overdrive_enable_wr_en = 1'b1;
    overdrive_magnitude = 4'd7; overdrive_magnitude_wr_en = 1'b1;
    data_in = {32{16'h7FFF}}; input_index = 6'd0; data_wr_en = 1'b1;
    start = 1'b1;
    tick(); cyc++;
    overdrive_enable_wr_en = 1'b0; overdrive_magnitude_wr_en = 1'b0;
    data_wr_en = 1'b0; start = 1'b0;
    cfg_od = 1; cfg_m = 7;
    chk("midcfg_still_run", 512'(state_dbg), 512'(1));
    wait_done("midcfg");
    check_frame("midcfg");
    run_and_check("nextcfg");

    // Reset in the middle of a frame
    set_cfg(5, 1, 5, 1);
    write_coeff(7, 8'h5A);
    start_frame("abort");
    repeat (500) tick();
    rst_n = 1'b0;
    #1;
    cfg_s = 0; cfg_od = 0; cfg_m = 0; cfg_tr = 0;
    chk("abort_done", 512'(done), 512'(0));
    chk("abort_state", 512'(state_dbg), 512'(0));
    freq_coeff_index = 11'd7;
    #1;
    chk("abort_coeff", 512'(coeff_rd), 512'(0));
    #3 rst_n = 1'b1;
    repeat (20) tick();
    chk("abort_done_low", 512'(done), 512'(0));
    load_frame();
    run_and_check("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
